// File: rtl/trap_ctrl_pkg.sv
// Shared encodings for the machine-mode trap sequencer: decoded instructions,
// exception causes, FSM states and the mstatus bit shuffles.
package trap_ctrl_pkg;

  localparam logic [31:0] INST_ECALL  = 32'h00000073;
  localparam logic [31:0] INST_EBREAK = 32'h00100073;
  localparam logic [31:0] INST_MRET   = 32'h30200073;

  localparam logic [31:0] CAUSE_ECALL_M = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK  = 32'd3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    S_MEPC    = 3'd1,
    S_MCAUSE  = 3'd2,
    S_MSTATUS = 3'd3,
    S_JUMP    = 3'd4,
    M_RESTORE = 3'd5,
    M_JUMP    = 3'd6
  } trap_state_e;

  // Trap entry: MPIE takes the old MIE, MIE is cleared.
  function automatic logic [31:0] trap_mstatus(input logic [31:0] m);
    logic [31:0] r;
    r    = m;
    r[7] = m[3];
    r[3] = 1'b0;
    return r;
  endfunction

  // MRET: MIE takes MPIE back, MPIE is set.
  function automatic logic [31:0] mret_mstatus(input logic [31:0] m);
    logic [31:0] r;
    r    = m;
    r[3] = m[7];
    r[7] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Decode-slot, CSR and pipeline-control bundle between the core and trap_ctrl.
interface trap_ctrl_if;

  logic [31:0] inst_i;
  logic [31:0] inst_addr_i;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        irq_i;
  logic [31:0] mtvec_i;
  logic [31:0] mepc_i;
  logic [31:0] mstatus_i;

  logic        csr_we_o;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic        hold_flag_o;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic        busy_o;

  modport slave (
    input  inst_i, inst_addr_i, jump_flag_i, jump_addr_i, irq_i,
           mtvec_i, mepc_i, mstatus_i,
    output csr_we_o, csr_waddr_o, csr_wdata_o, hold_flag_o,
           jump_flag_o, jump_addr_o, busy_o
  );

  modport master (
    output inst_i, inst_addr_i, jump_flag_i, jump_addr_i, irq_i,
           mtvec_i, mepc_i, mstatus_i,
    input  csr_we_o, csr_waddr_o, csr_wdata_o, hold_flag_o,
           jump_flag_o, jump_addr_o, busy_o
  );

endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: detects ECALL/EBREAK/MRET/irq, writes the trap
// CSRs one per cycle while holding the pipeline, then redirects the PC.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter logic [11:0] CSR_MSTATUS = 12'h300,
  parameter logic [11:0] CSR_MEPC    = 12'h341,
  parameter logic [11:0] CSR_MCAUSE  = 12'h342,
  parameter logic [31:0] IRQ_CAUSE   = 32'h8000000B
) (
  input logic        clk,
  input logic        rst,
  trap_ctrl_if.slave bus
);

  trap_state_e state, next_state;
  logic [31:0] saved_pc, saved_cause;

  logic        is_ecall, is_ebreak, is_mret;
  logic        trap_hit, mret_hit, irq_take;
  logic [31:0] capture_pc, capture_cause;

  // A flushed decode slot never counts as a hit.
  assign is_ecall  = (bus.inst_i == INST_ECALL);
  assign is_ebreak = (bus.inst_i == INST_EBREAK);
  assign is_mret   = (bus.inst_i == INST_MRET);
  assign trap_hit  = ~bus.jump_flag_i & (is_ecall | is_ebreak);
  assign mret_hit  = ~bus.jump_flag_i & is_mret;
  assign irq_take  = bus.irq_i & bus.mstatus_i[3] & (state == IDLE);

  // An interrupt resumes at whatever would have executed next.
  assign capture_pc    = trap_hit ? bus.inst_addr_i :
                         (bus.jump_flag_i ? bus.jump_addr_i : bus.inst_addr_i);
  assign capture_cause = trap_hit ? (is_ecall ? CAUSE_ECALL_M : CAUSE_EBREAK) : IRQ_CAUSE;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      saved_pc    <= 32'h0;
      saved_cause <= 32'h0;
    end else begin
      state <= next_state;
      if (state == IDLE && next_state == S_MEPC) begin
        saved_pc    <= capture_pc;
        saved_cause <= capture_cause;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (trap_hit)      next_state = S_MEPC;
        else if (mret_hit) next_state = M_RESTORE;
        else if (irq_take) next_state = S_MEPC;
      end
      S_MEPC:    next_state = S_MCAUSE;
      S_MCAUSE:  next_state = S_MSTATUS;
      S_MSTATUS: next_state = S_JUMP;
      S_JUMP:    next_state = IDLE;
      M_RESTORE: next_state = M_JUMP;
      M_JUMP:    next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is asserted, even mid-sequence.
  always_comb begin
    bus.csr_we_o    = 1'b0;
    bus.csr_waddr_o = 12'h0;
    bus.csr_wdata_o = 32'h0;
    bus.hold_flag_o = 1'b0;
    bus.jump_flag_o = 1'b0;
    bus.jump_addr_o = 32'h0;
    bus.busy_o      = 1'b0;
    if (rst) begin
      bus.hold_flag_o = (state != IDLE) || (next_state != IDLE);
      bus.busy_o      = (state != IDLE);
      case (state)
        S_MEPC: begin
          bus.csr_we_o    = 1'b1;
          bus.csr_waddr_o = CSR_MEPC;
          bus.csr_wdata_o = saved_pc;
        end
        S_MCAUSE: begin
          bus.csr_we_o    = 1'b1;
          bus.csr_waddr_o = CSR_MCAUSE;
          bus.csr_wdata_o = saved_cause;
        end
        S_MSTATUS: begin
          bus.csr_we_o    = 1'b1;
          bus.csr_waddr_o = CSR_MSTATUS;
          bus.csr_wdata_o = trap_mstatus(bus.mstatus_i);
        end
        S_JUMP: begin
          bus.jump_flag_o = 1'b1;
          bus.jump_addr_o = bus.mtvec_i & 32'hFFFF_FFFC;
        end
        M_RESTORE: begin
          bus.csr_we_o    = 1'b1;
          bus.csr_waddr_o = CSR_MSTATUS;
          bus.csr_wdata_o = mret_mstatus(bus.mstatus_i);
        end
        M_JUMP: begin
          bus.jump_flag_o = 1'b1;
          bus.jump_addr_o = bus.mepc_i;
        end
        default: ;
      endcase
    end
  end

endmodule
